serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder, successor to the single-bit adder cells.
- Adds two WIDTH-bit operands plus carry-in, processing BITS_PER_CYCLE bits per clock, LSB slice first, through one chained full-adder slice.
- Start/busy/done handshake; result held stable until the next accepted operation.
- Used where area matters more than latency, e.g. wide accumulators in slow control paths.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- BITS_PER_CYCLE, 1, bits added per clock; must divide WIDTH exactly. STEPS = WIDTH / BITS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result, registered
- cout  output  1  carry-out, registered

Interface note: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, carry and step-counter registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at a rising edge latches a, b, cin into internal registers, clears the step counter, moves to RUN. busy=1 from that edge.
- RUN: each edge adds the low BITS_PER_CYCLE bits of the A/B shift registers plus the carry register.
  - The slice result is shifted into the partial-sum register from the MSB end.
  - The carry register updates, A/B shift right by BITS_PER_CYCLE, and the counter increments.
  - On the edge that processes slice STEPS-1: sum loads the full partial sum, cout loads the final carry, state moves to DONE.
- DONE: lasts exactly one cycle; done=1, busy=0. Next edge returns to IDLE, unless start=1, in which case the new operands are accepted exactly as from IDLE (back-to-back).
- Latency: start accepted at edge 0; done is high in the cycle after edge STEPS; sum/cout are valid from edge STEPS.
- sum/cout change only on the completion edge (or reset). They hold the previous result throughout RUN.
- start while busy=1 is ignored. Operands are not re-sampled, and a/b/cin may change freely during RUN.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- Reset mid-operation aborts immediately: no done pulse, and sum/cout return to 0.
- STEPS=1 (BITS_PER_CYCLE=WIDTH): RUN lasts one edge; done is high in the cycle after edge 1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: extra input port sub (1 bit), captured with the operands on an accepted start.
  - sub=1 computes a − b: the internal B register loads ~b and the carry register loads 1 (cin ignored).
  - In this mode cout=1 means no borrow (a ≥ b unsigned).
  - sub=0 behaves identically to the undefined build.
- Undefined: no sub port; addition only.

Test Plan (WIDTH=8, BITS_PER_CYCLE=1 unless stated):
- Reset: assert rst_n=0 asynchronously mid-cycle -> busy=0, done=0, sum=8'h00, cout=0 immediately, with no clock edge needed.
- a=8'h0F, b=8'h01, cin=0, start pulse -> busy high for 8 cycles; done pulses once in the cycle after edge 8; sum=8'h10, cout=0. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start pulse with a=8'hFF, b=8'h01, then start=1 with a=8'h00, b=8'h00 at edge 3 -> second request ignored; sum=8'h00, cout=1, one done pulse only.
- Back-to-back: start held high through the DONE cycle with a=8'h12, b=8'h34 -> first result presented, then a second done 8 cycles later with sum=8'h46, cout=0.
- Reset mid-operation: rst_n=0 after edge 3 of an op -> no done pulse; sum=0, cout=0. A new start after release gives a correct result.
- BITS_PER_CYCLE=4, a=8'h99, b=8'h88, cin=0 -> done after 2 edges; sum=8'h21, cout=1.
- With SERIAL_ADDER_SUB_EN: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder: {cout,sum} = a + b + cin, BITS_PER_CYCLE bits per clock through one slice, LSB first.
// Optional SERIAL_ADDER_SUB_EN adds a sub input selecting a - b (cout=1 means no borrow).
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [BPC:0]       slice_res;
    logic [WIDTH-1:0]   psum_shift;

    always_comb begin
        accept     = start && (state_q != RUN);
        slice_res  = {1'b0, a_q[BPC-1:0]} + {1'b0, b_q[BPC-1:0]} + (BPC+1)'(carry_q);
        // New slice enters at the MSB end; after STEPS shifts it is fully aligned.
        psum_shift = (psum_q >> BPC) | (WIDTH'(slice_res[BPC-1:0]) << (WIDTH - BPC));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                carry_d = slice_res[BPC];
                psum_d  = psum_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = psum_shift;
                    cout_d  = slice_res[BPC];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
`ifdef SERIAL_ADDER_SUB_EN
            if (sub) begin
                b_d     = ~b;
                carry_d = 1'b1;
            end
`endif
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 with BITS_PER_CYCLE of 1, 4 and 8.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, start4 = 1'b0, start8 = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] a = '0, b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       busy, done, cout, busy4, done4, cout4, busy8, done8, cout8;
    logic [7:0] sum, sum4, sum8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout));

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

    // Called at posedge+1; returns at edge0+1 after start is accepted.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges until done is seen (50 means it never came) and busy samples along the way.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = busy ? 1 : 0;
        while (n < 50) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        #3;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h exp 00", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %b exp 0", cout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int n, bc;
        start_op(8'h0F, 8'h01, 1'b0);
        wait_done(n, bc);
        tests++; if (n !== 8) begin fails++; $display("FAIL basic_latency got %0d exp 8", n); end
        tests++; if (bc !== 8) begin fails++; $display("FAIL basic_busy_cycles got %0d exp 8", bc); end
        tests++; if (sum !== 8'h10) begin fails++; $display("FAIL basic_sum got %h exp 10", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL basic_cout got %b exp 0", cout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_in_done got %b exp 0", busy); end
        @(posedge clk); #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        tests++; if (sum !== 8'h10) begin fails++; $display("FAIL basic_sum_hold got %h exp 10", sum); end
        start_op(8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #1;
        tests++; if (sum !== 8'h10) begin fails++; $display("FAIL run_sum_hold got %h exp 10", sum); end
        wait_done(n, bc);
        tests++; if (n !== 7) begin fails++; $display("FAIL ff_latency got %0d exp 7", n); end
        tests++; if (sum !== 8'hFF) begin fails++; $display("FAIL ff_sum got %h exp ff", sum); end
        tests++; if (cout !== 1'b1) begin fails++; $display("FAIL ff_cout got %b exp 1", cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start;
        int dcnt, dedge;
        logic [7:0] s_at;
        logic c_at;
        dcnt = 0; dedge = 0; s_at = 8'hxx; c_at = 1'bx;
        start_op(8'hFF, 8'h01, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'h5A; b = 8'hC3; cin = 1'b1;
        tests++; if (sum !== 8'hFF) begin fails++; $display("FAIL ignore_sum_hold got %h exp ff", sum); end
        for (int i = 4; i <= 16; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin dedge = i; s_at = sum; c_at = cout; end
            end
        end
        tests++; if (dcnt !== 1) begin fails++; $display("FAIL ignore_done_count got %0d exp 1", dcnt); end
        tests++; if (dedge !== 8) begin fails++; $display("FAIL ignore_done_edge got %0d exp 8", dedge); end
        tests++; if (s_at !== 8'h00) begin fails++; $display("FAIL ignore_sum got %h exp 00", s_at); end
        tests++; if (c_at !== 1'b1) begin fails++; $display("FAIL ignore_cout got %b exp 1", c_at); end
    endtask

    task automatic test_back_to_back;
        int n, bc;
        start_op(8'h01, 8'h02, 1'b0);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        wait_done(n, bc);
        tests++; if (sum !== 8'h03) begin fails++; $display("FAIL b2b_first_sum got %h exp 03", sum); end
        @(posedge clk); #1;
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got %b exp 1", busy); end
        wait_done(n, bc);
        tests++; if (n !== 8) begin fails++; $display("FAIL b2b_latency got %0d exp 8", n); end
        tests++; if (sum !== 8'h46) begin fails++; $display("FAIL b2b_sum got %h exp 46", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL b2b_cout got %b exp 0", cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int n, bc, dcnt;
        dcnt = 0;
        start_op(8'hA0, 8'hB0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL midrst_sum got %h exp 00", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL midrst_cout got %b exp 0", cout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        tests++; if (dcnt !== 0) begin fails++; $display("FAIL midrst_no_done got %0d exp 0", dcnt); end
        start_op(8'h3C, 8'h44, 1'b1);
        wait_done(n, bc);
        tests++; if (sum !== 8'h81) begin fails++; $display("FAIL midrst_new_sum got %h exp 81", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL midrst_new_cout got %b exp 0", cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_wide_slices;
        int n;
        a = 8'h99; b = 8'h88; cin = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        while (n < 20) begin @(posedge clk); #1; n++; if (done4) break; end
        tests++; if (n !== 2) begin fails++; $display("FAIL bpc4_latency got %0d exp 2", n); end
        tests++; if (sum4 !== 8'h21) begin fails++; $display("FAIL bpc4_sum got %h exp 21", sum4); end
        tests++; if (cout4 !== 1'b1) begin fails++; $display("FAIL bpc4_cout got %b exp 1", cout4); end
        a = 8'hA5; b = 8'h5A; cin = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        tests++; if (busy8 !== 1'b1) begin fails++; $display("FAIL bpc8_busy got %b exp 1", busy8); end
        n = 0;
        while (n < 20) begin @(posedge clk); #1; n++; if (done8) break; end
        tests++; if (n !== 1) begin fails++; $display("FAIL bpc8_latency got %0d exp 1", n); end
        tests++; if (sum8 !== 8'h00) begin fails++; $display("FAIL bpc8_sum got %h exp 00", sum8); end
        tests++; if (cout8 !== 1'b1) begin fails++; $display("FAIL bpc8_cout got %b exp 1", cout8); end
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int n, bc;
        sub = 1'b1;
        start_op(8'h05, 8'h07, 1'b0);
        wait_done(n, bc);
        tests++; if (sum !== 8'hFE) begin fails++; $display("FAIL sub_sum got %h exp fe", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL sub_cout got %b exp 0", cout); end
        start_op(8'h07, 8'h05, 1'b0);
        wait_done(n, bc);
        tests++; if (sum !== 8'h02) begin fails++; $display("FAIL sub2_sum got %h exp 02", sum); end
        tests++; if (cout !== 1'b1) begin fails++; $display("FAIL sub2_cout got %b exp 1", cout); end
        sub = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_wide_slices();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
